// File: rtl/mips_fetch_pkg.sv
// Shared fetch definitions: FSM state encoding, PC step size,
// default reset PC and the word-alignment helper for redirect targets.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        REQ        = 2'd1,
        HOLD       = 2'd2,
        FLUSH      = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_next_pc_mux.sv
// Next-PC 2:1 select for the fetch unit.
// Ports: pc_inc (PC+4), target (redirect), sel (1 = target), next_pc.
module ifetch_next_pc_mux (
    input  logic [31:0] pc_inc,
    input  logic [31:0] target,
    input  logic        sel,
    output logic [31:0] next_pc
);

    assign next_pc = sel ? target : pc_inc;

endmodule

// File: rtl/ifetch_pc_ctrl.sv
// Instruction fetch PC controller: issues one request at a time, holds the
// returned word for decode and applies jump/branch redirects.
// Ports: clk, rst_n (sync, active low); imem_req/imem_addr/imem_ack/
// imem_rdata memory side; instr_valid/instr/instr_pc/id_ready decode side;
// branch_taken/branch_target, jump/jump_target redirects; pc_sel mux select.
module ifetch_pc_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        id_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        pc_sel
);

    fetch_state_e state;
    fetch_state_e state_nx;

    logic [31:0] pc;
    logic [31:0] tgt_q;
    logic [31:0] tgt_nx;
    logic [31:0] redir_tgt;
    logic [31:0] mux_tgt;
    logic [31:0] next_pc;
    logic        redir;
    logic        sel;
    logic        pc_load;
    logic        capture;

    assign redir     = jump | branch_taken;
    assign redir_tgt = align_word(jump ? jump_target : branch_target);

    always_comb begin
        state_nx = state;
        tgt_nx   = tgt_q;
        mux_tgt  = redir_tgt;
        sel      = 1'b0;
        pc_load  = 1'b0;
        capture  = 1'b0;
        unique case (state)
            RESET_WAIT: begin
                state_nx = REQ;
            end
            REQ: begin
                if (redir) begin
                    if (imem_ack) begin
                        sel     = 1'b1;
                        pc_load = 1'b1;
                    end else begin
                        state_nx = FLUSH;
                        tgt_nx   = redir_tgt;
                    end
                end else if (imem_ack) begin
                    state_nx = HOLD;
                    capture  = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    sel      = 1'b1;
                    pc_load  = 1'b1;
                    state_nx = REQ;
                end else if (id_ready) begin
                    pc_load  = 1'b1;
                    state_nx = REQ;
                end
            end
            FLUSH: begin
                // The old request is still in flight; it must complete
                // before the redirect target can be fetched.
                if (imem_ack) begin
                    sel      = 1'b1;
                    pc_load  = 1'b1;
                    state_nx = REQ;
                    if (!redir) mux_tgt = tgt_q;
                end else if (redir) begin
                    tgt_nx = redir_tgt;
                end
            end
            default: begin
                state_nx = RESET_WAIT;
            end
        endcase
    end

    ifetch_next_pc_mux u_next_pc (
        .pc_inc  (pc + PC_INC),
        .target  (mux_tgt),
        .sel     (pc_sel),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RESET_WAIT;
            pc       <= RESET_PC;
            tgt_q    <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= state_nx;
            tgt_q <= tgt_nx;
            if (pc_load) pc <= next_pc;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

    assign pc_sel      = rst_n & sel;
    assign imem_req    = (state == REQ) || (state == FLUSH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

endmodule

// File: doc/ifetch_pc_ctrl.md
IFETCH_PC_CTRL -- requirements
Module: ifetch_pc_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address (current PC).
REQ-007 imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-010 instr  output  32  instruction to decode.
REQ-011 instr_pc  output  32  PC of instr.
REQ-012 id_ready  input  1  decode accepts instr this cycle.
REQ-013 branch_taken  input  1  one-cycle redirect pulse to branch_target.
REQ-014 branch_target  input  32  branch destination.
REQ-015 jump  input  1  one-cycle redirect pulse to jump_target.
REQ-016 jump_target  input  32  jump destination.
REQ-017 pc_sel  output  1  select for the fetch next-PC mux: 0 = PC+4, 1 = redirect target.

Function
REQ-018 The FSM SHALL have the states RESET_WAIT, REQ, HOLD and FLUSH.
- RESET_WAIT: one cycle after reset release, then REQ.
- REQ: imem_req = 1; on imem_ack go to HOLD.
- HOLD: instr_valid = 1; on id_ready, PC advances and the FSM returns to REQ in the same edge.
- FLUSH: a redirect has arrived while REQ is outstanding; on imem_ack discard the data and go to REQ at the redirect target.
REQ-019 Fetch latency SHALL be one cycle: instr_valid rises on the edge after imem_ack.
REQ-020 instr and instr_pc SHALL be stable while instr_valid = 1 and id_ready = 0.
REQ-021 imem_addr SHALL be stable while imem_req = 1 and no ack has been received.
REQ-022 Redirect priority SHALL be jump over branch_taken; simultaneous pulses use jump_target.
REQ-023 The redirect target SHALL have bits [1:0] forced to 0.
REQ-024 Redirect in HOLD: instr_valid deasserts on the next edge, the instruction is dropped, PC loads the target, and the FSM goes to REQ.
REQ-025 Redirect in REQ without ack: go to FLUSH and latch the target.
REQ-026 Redirect in REQ with ack in the same cycle: drop the data, load the target, stay in REQ.
REQ-027 Redirect in FLUSH: the newer target overwrites the latched target.
REQ-028 pc_sel SHALL be 1 for exactly the cycle in which the PC loads a redirect target, and 0 otherwise.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).

Reset
REQ-030 On rst_n = 0 at a clock edge, outputs SHALL reset to: PC = RESET_PC, imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, pc_sel = 0, state = RESET_WAIT, and the latched target cleared.
REQ-031 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack SHALL be ignored until REQ is re-entered.

Structure
REQ-032 A shared package mips_fetch_pkg SHALL hold the FSM state encodings, the PC increment constant (4) and RESET_PC.
REQ-033 The next-PC 2:1 selection SHALL be a separate instantiated sub-module, ifetch_next_pc_mux, driven by pc_sel.

Verification
REQ-034 Reset, then 3 fetches with ack after 0, 2 and 1 wait cycles and id_ready = 1 -> instr_pc = 0x0, 0x4, 0x8 and instr equals the returned words.
REQ-035 id_ready held 0 for 5 cycles in HOLD -> instr and instr_pc unchanged, and no new imem_req.
REQ-036 branch_taken to 0x100 in HOLD at PC 0x8 -> instruction dropped, pc_sel pulses, next imem_addr = 0x100.
REQ-037 jump to 0x200 and branch to 0x300 in the same cycle during REQ (no ack) -> FLUSH, fetched word discarded after ack, next imem_addr = 0x200.
REQ-038 RESET_PC = 32'hFFFFFFFC -> second fetch address is 0x0.
REQ-039 rst_n low while imem_req is pending, with ack arriving during reset -> no instr_valid, and imem_addr = RESET_PC after RESET_WAIT.
